// File: rtl/memwr_stage.sv
// MEM->WB pipeline stage: multi-lane writeback latch with valid/ready handshake,
// optional skid entry, synchronous flush, $zero write suppression and retire counter.
module memwr_stage #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 5,
    parameter int LANES         = 1,
    parameter int SKID          = 1,
    parameter int ZERO_SUPPRESS = 1,
    parameter int CNT_W         = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES-1:0]         in_regwr,
    input  logic [LANES*DATA_W-1:0]  in_data,
    input  logic [LANES*ADDR_W-1:0]  in_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES-1:0]         out_regwr,
    output logic [LANES*DATA_W-1:0]  out_data,
    output logic [LANES*ADDR_W-1:0]  out_addr,
    output logic [CNT_W-1:0]         retire_cnt
);

    logic                    m_valid;
    logic [LANES-1:0]        m_regwr;
    logic [LANES*DATA_W-1:0] m_data;
    logic [LANES*ADDR_W-1:0] m_addr;

    logic                    s_valid;
    logic [LANES-1:0]        s_regwr;
    logic [LANES*DATA_W-1:0] s_data;
    logic [LANES*ADDR_W-1:0] s_addr;

    logic [LANES-1:0]        cap_regwr;
    logic [CNT_W-1:0]        retire_inc;
    logic                    accept;
    logic                    transfer;

    // Writes to $zero are dropped at capture so they never reach the counter or regfile.
    always_comb begin
        cap_regwr = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cap_regwr[i] = in_regwr[i]
                         & ~((ZERO_SUPPRESS != 0) & (in_addr[i*ADDR_W +: ADDR_W] == '0));
        end
    end

    always_comb begin
        if (SKID != 0) begin
            in_ready = reset & ~stall & ~flush & ~s_valid;
        end else begin
            in_ready = reset & ~stall & ~flush & (~m_valid | out_ready);
        end
    end

    assign accept    = in_valid & in_ready;
    assign transfer  = m_valid & out_ready;
    assign out_valid = m_valid;
    assign out_regwr = m_regwr & {LANES{m_valid}};
    assign out_data  = m_data;
    assign out_addr  = m_addr;

    always_comb begin
        retire_inc = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            retire_inc = retire_inc + CNT_W'(out_regwr[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid    <= 1'b0;
            m_regwr    <= '0;
            m_data     <= '0;
            m_addr     <= '0;
            s_valid    <= 1'b0;
            s_regwr    <= '0;
            s_data     <= '0;
            s_addr     <= '0;
            retire_cnt <= '0;
        end else begin
            if (transfer) begin
                retire_cnt <= retire_cnt + retire_inc;
            end
            if (flush) begin
                m_valid <= 1'b0;
                s_valid <= 1'b0;
            end else if (SKID != 0) begin
                // Skid drains into main first; a full stage cannot accept, so no three-way conflict.
                if (transfer && s_valid) begin
                    m_regwr <= s_regwr;
                    m_data  <= s_data;
                    m_addr  <= s_addr;
                    s_valid <= 1'b0;
                end else if (accept && (!m_valid || transfer)) begin
                    m_valid <= 1'b1;
                    m_regwr <= cap_regwr;
                    m_data  <= in_data;
                    m_addr  <= in_addr;
                end else if (accept) begin
                    s_valid <= 1'b1;
                    s_regwr <= cap_regwr;
                    s_data  <= in_data;
                    s_addr  <= in_addr;
                end else if (transfer) begin
                    m_valid <= 1'b0;
                end
            end else begin
                if (accept) begin
                    m_valid <= 1'b1;
                    m_regwr <= cap_regwr;
                    m_data  <= in_data;
                    m_addr  <= in_addr;
                end else if (transfer) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/memwr_stage.md
Name: memwr_stage

Overview:
- Parametrised MEM→WB pipeline stage register. Generalises the single-lane, stall-only MEM/WB latch.
- Adds multi-lane writeback for dual-issue, and a valid/ready handshake on both sides.
- Adds an optional skid buffer, synchronous flush, $zero write suppression and a retired-write counter.
- Sits between the memory stage and the register-file write port.

Parameters:
DATA_W, 32, writeback data width per lane
ADDR_W, 5, destination register address width
LANES, 1, independent writeback lanes (1..4)
SKID, 1, 1 = two-entry (main + skid) buffering; 0 = single register
ZERO_SUPPRESS, 1, 1 = force regwr low when dest addr == 0
CNT_W, 32, retire counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of all held entries
stall  in  1  hazard-unit stall; blocks input acceptance only
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
in_regwr  in  LANES  per-lane register write enable
in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_addr  in  LANES*ADDR_W  lane i at bits [i*ADDR_W +: ADDR_W]
out_valid  out  1  main entry valid
out_ready  in  1  writeback consumes
out_regwr  out  LANES  per-lane write enable, gated by out_valid
out_data  out  LANES*DATA_W  main entry data
out_addr  out  LANES*ADDR_W  main entry addresses
retire_cnt  out  CNT_W  count of retired register writes

Behaviour:
- Reset (reset=0, async):
  - m_valid, s_valid, out_regwr = 0.
  - out_data, out_addr, skid contents = 0.
  - retire_cnt = 0.
  - in_ready = 0 while reset is asserted.
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Capture rule:
  - lane regwr stored = in_regwr[i] & ~(ZERO_SUPPRESS & (in_addr lane i == 0)).
  - data and addr are stored unmodified.
- SKID=0:
  - in_ready = ~stall & ~flush & (~m_valid | out_ready).
  - On accept, main loads next edge: 1-cycle latency.
  - Transfer without accept → m_valid=0.
- SKID=1:
  - in_ready = ~stall & ~flush & ~s_valid. Depends on registered state only, apart from stall/flush.
  - Accept while main is empty, or draining this cycle → main.
  - Accept while main is held (m_valid & ~out_ready) → skid.
  - Transfer while s_valid → skid moves to main, s_valid=0.
  - Entries leave in strict acceptance order.
  - Full = s_valid=1 (two entries held); in_ready=0.
- stall:
  - Suppresses acceptance only; held entries keep draining.
  - Registers not loaded hold their value, including data bits of invalid entries.
- flush (synchronous, highest priority):
  - A transfer in the same cycle completes and is counted.
  - Next edge: m_valid=0 and s_valid=0. Any input that cycle is discarded (in_ready=0).
  - Data/addr registers are not cleared.
- out_regwr[i] = stored regwr[i] & m_valid. This makes a bubble never write the register file.
- retire_cnt:
  - On each transfer, += popcount(out_regwr).
  - Wraps modulo 2^CNT_W.
  - Not reset by flush.
- Reset mid-operation: all entries dropped immediately; the counter clears.

Test Plan:
- Reset, then LANES=1 SKID=0: in_valid=1, data=0xDEADBEEF, addr=5, regwr=1, out_ready=1 → next cycle out_valid=1, out_data=0xDEADBEEF, out_addr=5, out_regwr=1; following edge retire_cnt=1.
- SKID=1, out_ready=0:
  - Send A (data 0x11), then B (data 0x22) on consecutive cycles → in_ready=0 after B, and C is held off.
  - Raise out_ready → A, then B, in order; in_ready returns to 1 the cycle after A drains.
- ZERO_SUPPRESS=1, LANES=2: lane0 addr=0 regwr=1, lane1 addr=7 regwr=1 → out_regwr=2'b10; retire_cnt +1 on transfer.
- Two entries held, out_ready=1, flush=1 in one cycle → main entry transfers and counts; next cycle out_valid=0, out_regwr=0, in_ready=1.
- stall=1 with in_valid=1 for 3 cycles while held entry drains → no acceptance; out_valid falls after drain; accept resumes the cycle stall drops.
- CNT_W=4, retire 17 single-lane writes → retire_cnt=1 (wrap); assert reset=0 asynchronously mid-transfer → outputs 0 before next clk edge.
